// File: rtl/bt_pkg.sv
// Shared constants and types for the Bluetooth status transmitter.
// BT_TX_CHECKSUM_EN selects the 8-byte frame with a trailing XOR checksum byte.
package bt_pkg;

  // Game-state codes, kept in step with the defines used by top.
  typedef enum logic [2:0] {
    GsInit  = 3'd0,
    GsGame  = 3'd1,
    GsStart = 3'd2,
    GsLose  = 3'd3,
    GsWin   = 3'd4
  } game_state_e;

  localparam logic [7:0] AsciiG    = 8'h47;
  localparam logic [7:0] AsciiLf   = 8'h0A;
  localparam logic [7:0] AsciiZero = 8'h30;

`ifdef BT_TX_CHECKSUM_EN
  localparam int unsigned FrameLen = 8;
`else
  localparam int unsigned FrameLen = 7;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StGap
  } bt_tx_state_e;

  // Uppercase hex digit; 8'h37 is 'A' - 10.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (AsciiZero + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with valid/ready handshake; each bit lasts Div clock cycles.
// Used by bluetooth_status_tx (frame layout depends on BT_TX_CHECKSUM_EN there).
module uart_tx_byte #(
  parameter int unsigned Div = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [9:0]      shift_q, shift_d;
  logic            active_q, active_d;
  logic            bit_end;

  assign bit_end = active_q && (cnt_q == CntW'(Div - 1));
  assign done_o  = bit_end && (bit_q == 4'd9);
  // The final stop-bit cycle counts as idle so a new start bit follows with no gap.
  assign ready_o = !active_q || done_o;
  assign tx_o    = shift_q[0];

  always_comb begin
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    active_d = active_q;
    if (active_q) begin
      if (bit_end) begin
        cnt_d   = '0;
        bit_d   = bit_q + 4'd1;
        shift_d = {1'b1, shift_q[9:1]};
        if (done_o) begin
          active_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (valid_i && ready_o) begin
      active_d = 1'b1;
      cnt_d    = '0;
      bit_d    = '0;
      shift_d  = {1'b1, data_i, 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/bluetooth_status_tx.sv
// Sends an ASCII status frame "G<s><hhhh>\n" on stable change of {game_state, length} or on
// force_report. Define BT_TX_CHECKSUM_EN to insert an XOR checksum byte before the LF.
module bluetooth_status_tx
  import bt_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  game_state,
  input  logic [12:0] length,
  input  logic        force_report,
  output logic        tx,
  output logic        busy
);

  // Bit period; the integrator must keep CLK_HZ / BAUD >= 2.
  localparam int unsigned Div = CLK_HZ / BAUD;

  logic [15:0]  sample_q, prev_q, stable_q, stable_val;
  logic [15:0]  last_q, last_d, snap_q, snap_d;
  logic         force_pend_q, force_pend_d;
  bt_tx_state_e state_q, state_d;
  logic [2:0]   byte_idx_q, byte_idx_d;
  logic         pending, load;
  logic         ser_valid, ser_ready, ser_done;
  logic [7:0]   ser_data, next_byte;

  function automatic logic [7:0] body_byte(input logic [2:0] idx, input logic [15:0] snap);
    logic [7:0] b;
    case (idx)
      3'd0:    b = AsciiG;
      3'd1:    b = AsciiZero + {5'b0, snap[15:13]};
      3'd2:    b = hex_ascii({3'b000, snap[12]});
      3'd3:    b = hex_ascii(snap[11:8]);
      3'd4:    b = hex_ascii(snap[7:4]);
      3'd5:    b = hex_ascii(snap[3:0]);
      default: b = AsciiLf;
    endcase
    return b;
  endfunction

  // A value is only believed once two consecutive samples agree; otherwise hold the old one.
  assign stable_val = (sample_q == prev_q) ? sample_q : stable_q;
  assign pending    = force_pend_q || (stable_val != last_q);
  assign busy       = (state_q == StSend);

`ifdef BT_TX_CHECKSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = 8'h00;
    for (int unsigned i = 0; i < 6; i++) begin
      csum = csum ^ body_byte(3'(i), snap_q);
    end
  end

  assign next_byte = (byte_idx_q + 3'd1 == 3'd6) ? csum : body_byte(byte_idx_q + 3'd1, snap_q);
`else
  assign next_byte = body_byte(byte_idx_q + 3'd1, snap_q);
`endif

  // A force pulse arriving in the LOAD cycle wins over the clear, so it is never dropped.
  assign force_pend_d = force_report || (force_pend_q && !load);

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    snap_d     = snap_q;
    last_d     = last_q;
    load       = 1'b0;
    ser_valid  = 1'b0;
    ser_data   = AsciiG;
    unique case (state_q)
      StIdle: begin
        if (pending) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        load       = 1'b1;
        snap_d     = stable_val;
        last_d     = stable_val;
        byte_idx_d = '0;
        ser_valid  = 1'b1;
        ser_data   = AsciiG;
        state_d    = StSend;
      end
      StSend: begin
        if (ser_done) begin
          if (byte_idx_q == 3'(FrameLen - 1)) begin
            state_d = StGap;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            ser_valid  = 1'b1;
            ser_data   = next_byte;
          end
        end
      end
      StGap: begin
        // Pass through IDLE without spending a cycle there when a report is already due.
        state_d = pending ? StLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_q     <= '0;
      prev_q       <= '0;
      stable_q     <= '0;
      last_q       <= '0;
      snap_q       <= '0;
      force_pend_q <= 1'b0;
      state_q      <= StIdle;
      byte_idx_q   <= '0;
    end else begin
      sample_q     <= {game_state, length};
      prev_q       <= sample_q;
      stable_q     <= stable_val;
      last_q       <= last_d;
      snap_q       <= snap_d;
      force_pend_q <= force_pend_d;
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
    end
  end

  uart_tx_byte #(
    .Div(Div)
  ) u_uart_tx_byte (
    .clk_i  (clk),
    .rst_ni (rst),
    .valid_i(ser_valid),
    .data_i (ser_data),
    .ready_o(ser_ready),
    .done_o (ser_done),
    .tx_o   (tx)
  );

  // The framer only issues bytes in LOAD or on a stop-bit end, when the serialiser is ready.
  logic unused_ready;
  assign unused_ready = ser_ready;

endmodule

// File: tb/tb_bluetooth_status_tx.sv
// Directed bench for bluetooth_status_tx at CLK_HZ=1000, BAUD=100 (10 cycles per bit).
// Build with BT_TX_CHECKSUM_EN defined to exercise the 8-byte frame.
module tb_bluetooth_status_tx;

  localparam int DIV = 10;
`ifdef BT_TX_CHECKSUM_EN
  localparam int FLEN = 8;
`else
  localparam int FLEN = 7;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  game_state = 3'd0;
  logic [12:0] length = 13'd0;
  logic        force_report = 1'b0;
  logic        tx, busy;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [63:0] rx_word, exp_word;
  int rx_timeout, rx_width_err, rx_frame_err, rx_busy_err, rx_gap_err;
  int rx_t_start, rx_t_end;

  bluetooth_status_tx #(
    .CLK_HZ(1000),
    .BAUD  (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .game_state  (game_state),
    .length      (length),
    .force_report(force_report),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // body holds the six leading bytes, first byte in the top position.
  function automatic logic [63:0] make_frame(input logic [47:0] body);
    logic [63:0] w;
    logic [7:0]  x;
    w = '0;
    x = 8'h00;
    for (int i = 0; i < 6; i++) begin
      w[8*i +: 8] = body[8*(5-i) +: 8];
      x = x ^ body[8*(5-i) +: 8];
    end
`ifdef BT_TX_CHECKSUM_EN
    w[48 +: 8] = x;
    w[56 +: 8] = 8'h0A;
`else
    w[48 +: 8] = 8'h0A;
`endif
    return w;
  endfunction

  // Receives one frame, sampling every falling edge; ends on the sample just after the frame.
  task automatic recv_frame(input int budget);
    int   waited;
    logic bv;
    waited       = 0;
    rx_timeout   = 0;
    rx_word      = '0;
    rx_width_err = 0;
    rx_frame_err = 0;
    rx_busy_err  = 0;
    rx_gap_err   = 0;
    rx_t_start   = 0;
    rx_t_end     = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx !== 1'b0 && waited < budget);
    if (tx !== 1'b0) begin
      rx_timeout = 1;
      return;
    end
    rx_t_start = cyc;
    bv = 1'b0;
    for (int k = 0; k < FLEN; k++) begin
      for (int j = 0; j < 10; j++) begin
        for (int c = 0; c < DIV; c++) begin
          if (!(k == 0 && j == 0 && c == 0)) @(negedge clk);
          if (c == 0) bv = tx;
          else if (tx !== bv) rx_width_err++;
          if (busy !== 1'b1) rx_busy_err++;
        end
        if (j == 0 && bv !== 1'b0) rx_frame_err++;
        else if (j == 9 && bv !== 1'b1) rx_frame_err++;
        else if (j >= 1 && j <= 8) rx_word[8*k + j - 1] = bv;
      end
    end
    @(negedge clk);
    rx_t_end = cyc;
    if (busy !== 1'b0 || tx !== 1'b1) rx_gap_err = 1;
  endtask

  task automatic quiet(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_tx: tx=%b in reset, expected 1", tx);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: busy=%b in reset, expected 0", busy);
    end
    rst = 1'b1;
    quiet(1000, bad);
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reset_idle: %0d non-idle samples in 1000 cycles, expected 0", bad);
    end
  endtask

  task automatic test_basic_frame();
    int c0, bad;
    @(posedge clk);
    #1;
    game_state = 3'd1;
    length     = 13'd3;
    c0         = cyc;
    recv_frame(200);
    exp_word = make_frame(48'h47_31_30_30_30_33);
    tests_run++;
    if (rx_timeout != 0) begin
      tests_failed++;
      $display("FAIL basic_timeout: no start bit within 200 cycles, expected a frame");
    end
    tests_run++;
    if (rx_word !== exp_word) begin
      tests_failed++;
      $display("FAIL basic_bytes: got %h, expected %h", rx_word, exp_word);
    end
    tests_run++;
    if (rx_width_err != 0 || rx_frame_err != 0) begin
      tests_failed++;
      $display("FAIL basic_bits: width errors %0d framing errors %0d, expected 0 and 0",
               rx_width_err, rx_frame_err);
    end
    tests_run++;
    if (rx_busy_err != 0 || rx_gap_err != 0) begin
      tests_failed++;
      $display("FAIL basic_busy: busy-low samples %0d gap error %0d, expected 0 and 0",
               rx_busy_err, rx_gap_err);
    end
    tests_run++;
    if (rx_t_start - c0 != 4) begin
      tests_failed++;
      $display("FAIL basic_latency: start bit %0d cycles after change, expected 4",
               rx_t_start - c0);
    end
    tests_run++;
    if (rx_t_end - rx_t_start != FLEN * 10 * DIV) begin
      tests_failed++;
      $display("FAIL basic_duration: frame %0d cycles, expected %0d",
               rx_t_end - rx_t_start, FLEN * 10 * DIV);
    end
`ifdef BT_TX_CHECKSUM_EN
    tests_run++;
    if (rx_word[48 +: 8] !== 8'h75 || rx_t_end - rx_t_start != 800) begin
      tests_failed++;
      $display("FAIL checksum: byte %h over %0d cycles, expected 75 over 800",
               rx_word[48 +: 8], rx_t_end - rx_t_start);
    end
`endif
    quiet(200, bad);
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL basic_no_repeat: %0d non-idle samples, expected 0", bad);
    end
  endtask

  task automatic test_hex_and_glitch();
    int c0, bad;
    @(posedge clk);
    #1;
    game_state = 3'd4;
    length     = 13'h1A5;
    c0         = cyc;
    recv_frame(200);
    exp_word = make_frame(48'h47_34_30_31_41_35);
    tests_run++;
    if (rx_timeout != 0 || rx_word !== exp_word) begin
      tests_failed++;
      $display("FAIL hex_bytes: got %h (timeout %0d), expected %h", rx_word, rx_timeout,
               exp_word);
    end
    tests_run++;
    if (rx_t_start - c0 != 4) begin
      tests_failed++;
      $display("FAIL hex_latency: start bit %0d cycles after change, expected 4",
               rx_t_start - c0);
    end
    @(posedge clk);
    #1;
    length = 13'd7;
    @(posedge clk);
    #1;
    length = 13'h1A5;
    quiet(300, bad);
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL glitch_ignored: %0d non-idle samples after glitch, expected 0", bad);
    end
  endtask

  task automatic test_changes_mid_frame();
    int end1, bad, waited;
    @(posedge clk);
    #1;
    game_state = 3'd1;
    fork
      recv_frame(200);
      begin
        waited = 0;
        while (busy !== 1'b1 && waited < 200) begin
          @(negedge clk);
          waited++;
        end
        repeat (205) @(posedge clk);
        #1;
        length = 13'd4;
        repeat (30) @(posedge clk);
        #1;
        length = 13'd5;
      end
    join
    end1 = rx_t_end;
    exp_word = make_frame(48'h47_31_30_31_41_35);
    tests_run++;
    if (rx_timeout != 0 || rx_word !== exp_word) begin
      tests_failed++;
      $display("FAIL mid_first: got %h (timeout %0d), expected %h", rx_word, rx_timeout,
               exp_word);
    end
    recv_frame(20);
    exp_word = make_frame(48'h47_31_30_30_30_35);
    tests_run++;
    if (rx_timeout != 0 || rx_word !== exp_word) begin
      tests_failed++;
      $display("FAIL mid_followup: got %h (timeout %0d), expected %h", rx_word, rx_timeout,
               exp_word);
    end
    tests_run++;
    if (rx_t_start - end1 != 2) begin
      tests_failed++;
      $display("FAIL mid_gap: follow-up start %0d cycles after busy fell, expected 2",
               rx_t_start - end1);
    end
    quiet(300, bad);
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL mid_single_followup: %0d non-idle samples, expected 0", bad);
    end
  endtask

  task automatic test_force_and_reset();
    int c0, bad, waited;
    @(posedge clk);
    #1;
    force_report = 1'b1;
    c0           = cyc;
    @(posedge clk);
    #1;
    force_report = 1'b0;
    recv_frame(200);
    exp_word = make_frame(48'h47_31_30_30_30_35);
    tests_run++;
    if (rx_timeout != 0 || rx_word !== exp_word) begin
      tests_failed++;
      $display("FAIL force_bytes: got %h (timeout %0d), expected %h", rx_word, rx_timeout,
               exp_word);
    end
    tests_run++;
    if (rx_t_start - c0 != 3) begin
      tests_failed++;
      $display("FAIL force_latency: start bit %0d cycles after pulse, expected 3",
               rx_t_start - c0);
    end
    // Second forced frame, reset while byte 1 is driving a 0 data bit.
    @(posedge clk);
    #1;
    force_report = 1'b1;
    @(posedge clk);
    #1;
    force_report = 1'b0;
    waited = 0;
    while (busy !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (125) @(posedge clk);
    #3;
    tests_run++;
    if (tx !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_precondition: tx=%b mid byte 1, expected 0", tx);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: tx=%b busy=%b, expected 1 and 0", tx, busy);
    end
    game_state = 3'd0;
    length     = 13'd0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    quiet(300, bad);
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reset_no_resume: %0d non-idle samples after release, expected 0", bad);
    end
    // Force and change sampled on the same edge give one frame.
    @(posedge clk);
    #1;
    game_state   = 3'd2;
    force_report = 1'b1;
    c0           = cyc;
    @(posedge clk);
    #1;
    force_report = 1'b0;
    recv_frame(200);
    exp_word = make_frame(48'h47_32_30_30_30_30);
    tests_run++;
    if (rx_timeout != 0 || rx_word !== exp_word || rx_t_start - c0 != 3) begin
      tests_failed++;
      $display("FAIL force_change_frame: got %h at +%0d (timeout %0d), expected %h at +3",
               rx_word, rx_t_start - c0, rx_timeout, exp_word);
    end
    quiet(300, bad);
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL force_change_single: %0d non-idle samples, expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_hex_and_glitch();
    test_changes_mid_frame();
    test_force_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
